// File: rtl/macro_seq_pkg.sv
// Shared types, opcode constants and Zcmp helper functions for the macro-op sequencer.
// Optional feature macro: ZCMP_MV_EN (adds cm.mva01s / cm.mvsa01 kinds).
package macro_seq_pkg;

`ifdef ZCMP_MV_EN
  typedef enum logic [2:0] {
    KIND_PUSH    = 3'd0,
    KIND_POP     = 3'd1,
    KIND_POPRET  = 3'd2,
    KIND_POPRETZ = 3'd3,
    KIND_MVA01S  = 3'd4,
    KIND_MVSA01  = 3'd5
  } macro_kind_e;
`else
  typedef enum logic [1:0] {
    KIND_PUSH    = 2'd0,
    KIND_POP     = 2'd1,
    KIND_POPRET  = 2'd2,
    KIND_POPRETZ = 2'd3
  } macro_kind_e;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] F3_ADD     = 3'b000;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_SP   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd10;
  localparam logic [4:0] REG_A1   = 5'd11;

  // rlist 4..14 covers ra plus rlist-4 s-regs; 15 also pulls in s10 and s11.
  function automatic logic [3:0] rlist_to_nregs(input logic [3:0] rlist);
    logic [3:0] n;
    if (rlist < 4'd4) begin
      n = 4'd0;
    end else if (rlist == 4'd15) begin
      n = 4'd13;
    end else begin
      n = rlist - 4'd3;
    end
    return n;
  endfunction

  function automatic logic [4:0] rlist_reg(input logic [3:0] idx);
    logic [4:0] r;
    case (idx)
      4'd0:    r = REG_RA;
      4'd1:    r = 5'd8;
      4'd2:    r = 5'd9;
      default: r = {1'b0, idx} + 5'd15;
    endcase
    return r;
  endfunction

  function automatic logic [11:0] stack_adj(input logic [3:0] nregs, input logic [1:0] spimm,
                                            input logic [3:0] slot_bytes);
    logic [11:0] raw;
    raw = {8'd0, nregs} * {8'd0, slot_bytes};
    return ((raw + 12'd15) & 12'hFF0) + {6'd0, spimm, 4'd0};
  endfunction

`ifdef ZCMP_MV_EN
  function automatic logic [4:0] sreg_to_reg(input logic [2:0] sreg);
    return (sreg < 3'd2) ? {2'b01, sreg} : {2'b10, sreg};
  endfunction
`endif

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

endpackage

// File: rtl/macro_op_sequencer_uop_gen.sv
// Combinational micro-op generator: (kind, rlist, spimm, idx) -> {instr, last}.
// Optional feature macro: ZCMP_MV_EN (two-move sequences).
module macro_uop_gen
  import macro_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
) (
  input  macro_kind_e      kind_i,
  input  logic [3:0]       rlist_i,
  input  logic [1:0]       spimm_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [31:0]      instr_o,
  output logic             last_o
);

  localparam logic [3:0] SLOT_B = 4'(XLEN / 8);
  localparam logic [2:0] F3_MEM = (XLEN == 64) ? 3'b011 : 3'b010;

  logic [3:0]  n_s;
  logic [11:0] adj_s;
  logic [11:0] off_s;
  logic [4:0]  idx_s;
  logic [4:0]  reg_s;
  logic [4:0]  total_s;
  logic        is_push_s;
`ifdef ZCMP_MV_EN
  logic [4:0]  r1s_s;
  logic [4:0]  r2s_s;
`endif

  // Build the micro-op at position idx; pops place li a0 before the final ret.
  always_comb begin
    n_s       = rlist_to_nregs(rlist_i);
    adj_s     = stack_adj(n_s, spimm_i, SLOT_B);
    idx_s     = 5'(idx_i);
    off_s     = ({7'd0, idx_s} + 12'd1) * {8'd0, SLOT_B};
    reg_s     = rlist_reg(idx_s[3:0]);
    is_push_s = (kind_i == KIND_PUSH);
    total_s   = {1'b0, n_s} + 5'd1
              + ((kind_i == KIND_POPRETZ) ? 5'd1 : 5'd0)
              + (((kind_i == KIND_POPRET) || (kind_i == KIND_POPRETZ)) ? 5'd1 : 5'd0);
    last_o    = (idx_s == (total_s - 5'd1));
    instr_o   = enc_i(12'd0, REG_ZERO, F3_ADD, REG_ZERO, OPC_OP_IMM);
`ifdef ZCMP_MV_EN
    r1s_s = sreg_to_reg(rlist_i[2:0]);
    r2s_s = sreg_to_reg({rlist_i[3], spimm_i});
    if ((kind_i == KIND_MVA01S) || (kind_i == KIND_MVSA01)) begin
      last_o = (idx_s == 5'd1);
      if (kind_i == KIND_MVA01S) begin
        instr_o = enc_i(12'd0, (idx_s == 5'd0) ? r1s_s : r2s_s, F3_ADD,
                        (idx_s == 5'd0) ? REG_A0 : REG_A1, OPC_OP_IMM);
      end else begin
        instr_o = enc_i(12'd0, (idx_s == 5'd0) ? REG_A0 : REG_A1, F3_ADD,
                        (idx_s == 5'd0) ? r1s_s : r2s_s, OPC_OP_IMM);
      end
    end else
`endif
    if (idx_s < {1'b0, n_s}) begin
      if (is_push_s) begin
        instr_o = enc_s(12'd0 - off_s, reg_s, REG_SP, F3_MEM, OPC_STORE);
      end else begin
        instr_o = enc_i(adj_s - off_s, REG_SP, F3_MEM, reg_s, OPC_LOAD);
      end
    end else if (idx_s == {1'b0, n_s}) begin
      if (is_push_s) begin
        instr_o = enc_i(12'd0 - adj_s, REG_SP, F3_ADD, REG_SP, OPC_OP_IMM);
      end else begin
        instr_o = enc_i(adj_s, REG_SP, F3_ADD, REG_SP, OPC_OP_IMM);
      end
    end else if ((kind_i == KIND_POPRETZ) && (idx_s == ({1'b0, n_s} + 5'd1))) begin
      instr_o = enc_i(12'd0, REG_ZERO, F3_ADD, REG_A0, OPC_OP_IMM);
    end else begin
      instr_o = enc_i(12'd0, REG_RA, F3_ADD, REG_ZERO, OPC_JALR);
    end
  end

endmodule

// File: rtl/macro_op_sequencer.sv
// Zcmp push/pop macro-op sequencer: FSM, micro-op index and issue/fetch handshake.
// Optional feature macro: ZCMP_MV_EN (mv kinds bypass the rlist legality check).
module macro_op_sequencer
  import macro_seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_UOPS = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        in_is_macro_i,
  input  macro_kind_e in_kind_i,
  input  logic [3:0]  in_rlist_i,
  input  logic [1:0]  in_spimm_i,
  output logic        out_valid_o,
  output logic [31:0] out_instr_o,
  output logic        out_last_o,
  output logic        out_illegal_o,
  input  logic        out_ack_i
);

  localparam int IDX_W = $clog2(MAX_UOPS);

  state_e           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [31:0]      uop_instr_s;
  logic             uop_last_s;
  logic             needs_rlist_s;
  logic             illegal_s;

  macro_uop_gen #(
    .XLEN  (XLEN),
    .IDX_W (IDX_W)
  ) u_uop_gen (
    .kind_i  (in_kind_i),
    .rlist_i (in_rlist_i),
    .spimm_i (in_spimm_i),
    .idx_i   (idx_r),
    .instr_o (uop_instr_s),
    .last_o  (uop_last_s)
  );

`ifdef ZCMP_MV_EN
  assign needs_rlist_s = (in_kind_i != KIND_MVA01S) && (in_kind_i != KIND_MVSA01);
`else
  assign needs_rlist_s = 1'b1;
`endif
  assign illegal_s = in_is_macro_i && needs_rlist_s && (in_rlist_i < 4'd4);

  // Output/handshake decode; passthrough is zero-latency, so these follow the inputs directly.
  always_comb begin
    out_valid_o   = 1'b0;
    in_ready_o    = 1'b0;
    out_instr_o   = in_instr_i;
    out_last_o    = 1'b0;
    out_illegal_o = 1'b0;
    if (!rst_ni || flush_i) begin
      out_valid_o = 1'b0;
    end else if (state_r == ST_SEQ) begin
      out_valid_o = 1'b1;
      out_instr_o = uop_instr_s;
      out_last_o  = uop_last_s;
      in_ready_o  = out_ack_i && uop_last_s;
    end else if (!in_is_macro_i) begin
      out_valid_o = in_valid_i;
      out_last_o  = in_valid_i;
      in_ready_o  = out_ack_i;
    end else if (illegal_s) begin
      out_valid_o   = in_valid_i;
      out_last_o    = in_valid_i;
      out_illegal_o = in_valid_i;
      in_ready_o    = in_valid_i && out_ack_i;
    end else begin
      out_valid_o = in_valid_i;
      out_instr_o = uop_instr_s;
      out_last_o  = in_valid_i && uop_last_s;
      in_ready_o  = in_valid_i && out_ack_i && uop_last_s;
    end
  end

  // Sequencer state and micro-op index; flush and reset both return to IDLE with idx 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_i && out_ack_i && in_is_macro_i && !illegal_s && !uop_last_s) begin
            state_r <= ST_SEQ;
            idx_r   <= {{(IDX_W-1){1'b0}}, 1'b1};
          end else begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
          end
        end
        ST_SEQ: begin
          if (out_ack_i && uop_last_s) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
          end else if (out_ack_i) begin
            state_r <= ST_SEQ;
            idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end else begin
            state_r <= ST_SEQ;
            idx_r   <= idx_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_macro_op_sequencer.sv
// Directed self-checking bench for macro_op_sequencer (XLEN=32, default build).
module tb_macro_op_sequencer;
  import macro_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = 32'd0;
  logic        in_is_macro_i = 1'b0;
  macro_kind_e in_kind_i = KIND_PUSH;
  logic [3:0]  in_rlist_i = 4'd0;
  logic [1:0]  in_spimm_i = 2'd0;
  logic        out_valid_o;
  logic [31:0] out_instr_o;
  logic        out_last_o;
  logic        out_illegal_o;
  logic        out_ack_i = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          stable_viol = 0;
  logic        hold_q = 1'b0;
  logic [47:0] snap_q = 48'd0;

  macro_op_sequencer #(.XLEN(32), .MAX_UOPS(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_instr_i    (in_instr_i),
    .in_is_macro_i (in_is_macro_i),
    .in_kind_i     (in_kind_i),
    .in_rlist_i    (in_rlist_i),
    .in_spimm_i    (in_spimm_i),
    .out_valid_o   (out_valid_o),
    .out_instr_o   (out_instr_o),
    .out_last_o    (out_last_o),
    .out_illegal_o (out_illegal_o),
    .out_ack_i     (out_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic l, input logic r,
                         input logic il);
    chk({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, v});
    chk({tag, ".last"}, {31'd0, out_last_o}, {31'd0, l});
    chk({tag, ".ready"}, {31'd0, in_ready_o}, {31'd0, r});
    chk({tag, ".illegal"}, {31'd0, out_illegal_o}, {31'd0, il});
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic l, input logic r);
    chk_ctl(tag, 1'b1, l, r, 1'b0);
    chk({tag, ".instr"}, out_instr_o, ins);
  endtask

  task automatic drive(input logic v, input logic m, input macro_kind_e k, input logic [3:0] rl,
                       input logic [1:0] sp, input logic [31:0] ins, input logic ack);
    in_valid_i    = v;
    in_is_macro_i = m;
    in_kind_i     = k;
    in_rlist_i    = rl;
    in_spimm_i    = sp;
    in_instr_i    = ins;
    out_ack_i     = ack;
  endtask

  // While a held instruction is not yet consumed, its payload must not move.
  task automatic settle();
    #1;
    if (hold_q && in_valid_i &&
        (48'({in_instr_i, in_is_macro_i, in_kind_i, in_rlist_i, in_spimm_i}) !== snap_q))
      stable_viol++;
  endtask

  task automatic tick();
    hold_q = rst_ni && in_valid_i && !in_ready_o && !flush_i;
    snap_q = 48'({in_instr_i, in_is_macro_i, in_kind_i, in_rlist_i, in_spimm_i});
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    settle();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    settle();
    chk_ctl("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    drive(1'b1, 1'b0, KIND_PUSH, 4'd0, 2'd0, 32'h00A00513, 1'b1);
    settle();
    chk_out("pass", 32'h00A00513, 1'b1, 1'b1);
    tick();

    drive(1'b1, 1'b1, KIND_PUSH, 4'd5, 2'd0, 32'h0000B852, 1'b1);
    settle(); chk_out("push0", 32'hFE112E23, 1'b0, 1'b0); tick();
    settle(); chk_out("push1", 32'hFE812C23, 1'b0, 1'b0); tick();
    settle(); chk_out("push2", 32'hFF010113, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, KIND_PUSH, 4'd0, 2'd0, 32'h00000013, 1'b0);
    settle(); chk_ctl("push_done", 1'b0, 1'b0, 1'b0, 1'b0); tick();

    drive(1'b1, 1'b1, KIND_POPRET, 4'd4, 2'd1, 32'h0000BE42, 1'b1);
    settle(); chk_out("popret0", 32'h01C12083, 1'b0, 1'b0); tick();
    settle(); chk_out("popret1", 32'h02010113, 1'b0, 1'b0); tick();
    settle(); chk_out("popret2", 32'h00008067, 1'b1, 1'b1); tick();

    drive(1'b1, 1'b1, KIND_PUSH, 4'd5, 2'd0, 32'h0000B852, 1'b1);
    settle(); chk_out("bp0", 32'hFE112E23, 1'b0, 1'b0); tick();
    out_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle(); chk_out("bp_hold", 32'hFE812C23, 1'b0, 1'b0); tick();
    end
    out_ack_i = 1'b1;
    settle(); chk_out("bp1", 32'hFE812C23, 1'b0, 1'b0); tick();
    settle(); chk_out("bp2", 32'hFF010113, 1'b1, 1'b1); tick();

    drive(1'b1, 1'b1, KIND_PUSH, 4'd6, 2'd0, 32'h0000B862, 1'b1);
    settle(); chk_out("fl0", 32'hFE112E23, 1'b0, 1'b0); tick();
    flush_i = 1'b1;
    settle(); chk_ctl("fl_cycle", 1'b0, 1'b0, 1'b0, 1'b0); tick();
    flush_i = 1'b0;
    drive(1'b1, 1'b0, KIND_PUSH, 4'd0, 2'd0, 32'h00B00593, 1'b1);
    settle(); chk_out("post_flush", 32'h00B00593, 1'b1, 1'b1); tick();

    drive(1'b1, 1'b1, KIND_PUSH, 4'd2, 2'd0, 32'h0000B822, 1'b0);
    settle(); chk_ctl("ill_wait", 1'b1, 1'b1, 1'b0, 1'b1); tick();
    out_ack_i = 1'b1;
    settle(); chk_ctl("ill_ack", 1'b1, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, KIND_PUSH, 4'd0, 2'd0, 32'h00000013, 1'b0);
    settle(); chk_ctl("ill_noseq", 1'b0, 1'b0, 1'b0, 1'b0); tick();

    drive(1'b1, 1'b1, KIND_POP, 4'd4, 2'd0, 32'h0000BA42, 1'b1);
    settle(); chk_out("pop0", 32'h00C12083, 1'b0, 1'b0); tick();
    settle(); chk_out("pop1", 32'h01010113, 1'b1, 1'b1);
    flush_i = 1'b1;
    settle(); chk_ctl("flush_last", 1'b0, 1'b0, 1'b0, 1'b0); tick();
    flush_i = 1'b0;
    drive(1'b0, 1'b0, KIND_PUSH, 4'd0, 2'd0, 32'h00000013, 1'b0);
    settle(); chk_ctl("flush_last_idle", 1'b0, 1'b0, 1'b0, 1'b0); tick();

    drive(1'b1, 1'b1, KIND_POPRETZ, 4'd4, 2'd0, 32'h0000BC42, 1'b1);
    settle(); chk_out("retz0", 32'h00C12083, 1'b0, 1'b0); tick();
    settle(); chk_out("retz1", 32'h01010113, 1'b0, 1'b0); tick();
    settle(); chk_out("retz2", 32'h00000513, 1'b0, 1'b0); tick();
    settle(); chk_out("retz3", 32'h00008067, 1'b1, 1'b1); tick();

    drive(1'b1, 1'b1, KIND_PUSH, 4'd5, 2'd0, 32'h0000B852, 1'b1);
    settle(); chk_out("rst_seq0", 32'hFE112E23, 1'b0, 1'b0); tick();
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, KIND_PUSH, 4'd0, 2'd0, 32'h00000013, 1'b0);
    settle(); chk_ctl("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0); tick();
    rst_ni = 1'b1;
    settle(); chk_ctl("after_mid_reset", 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, KIND_PUSH, 4'd5, 2'd0, 32'h0000B852, 1'b1);
    settle(); chk_out("restart0", 32'hFE112E23, 1'b0, 1'b0); tick();
    settle(); chk_out("restart1", 32'hFE812C23, 1'b0, 1'b0); tick();
    settle(); chk_out("restart2", 32'hFF010113, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, KIND_PUSH, 4'd0, 2'd0, 32'h00000013, 1'b0);

    chk("in_stable", 32'(stable_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
